switch_conditioner: RTL
=======================

# switch_conditioner

Input-side front end for the board's four slide/push switches. Each raw, asynchronous switch is synchronized, debounced, and edge-detected. The block drives clean levels, one-cycle press/release pulses and the four LEDs. It sits between the switch pins and all downstream logic, replacing the direct switch-to-LED wiring.

## Interface

Parameters:
- DEBOUNCE_LIMIT, 250000, consecutive stable clocks required to accept a new level (10 ms at 25 MHz); legal range 1..2^24-1
- CNT_W, $clog2(DEBOUNCE_LIMIT+1), counter width (derived; do not override)

Ports:
- iClk  input  1  system clock; the only clock
- iReset  input  1  reset; synchronous, active-high
- iSwitch_1..iSwitch_4  input  1 each  raw switch pins, asynchronous to iClk
- oSwitch_1..oSwitch_4  output  1 each  debounced switch level
- oPress_1..oPress_4  output  1 each  one-cycle pulse on debounced 0->1
- oRelease_1..oRelease_4  output  1 each  one-cycle pulse on debounced 1->0
- oLED_1..oLED_4  output  1 each  LED drive (see Configuration)

## Operation

- Each channel is independent and identical. There is no cross-channel interaction.
- Sync stage: two flops per channel (s1, s2). Both reset to 0. Only s2 is used downstream.
- Per-channel FSM with states S_LOW, S_RISE, S_HIGH, S_FALL. The counter cnt is CNT_W bits.
  - S_LOW: if s2=1, go to S_RISE with cnt<=1. Otherwise stay, with cnt<=0.
  - S_RISE: if s2=0, go to S_LOW with cnt<=0 (glitch rejected). Else if cnt==DEBOUNCE_LIMIT, go to S_HIGH with cnt<=0. Else cnt<=cnt+1.
  - S_HIGH and S_FALL: mirror S_LOW and S_RISE with polarity inverted.
  - DEBOUNCE_LIMIT==1: S_RISE/S_FALL accept on the first cycle they are entered if s2 is still mismatched.
- Outputs:
  - oSwitch is 1 in S_HIGH and S_FALL, and 0 otherwise.
  - oPress is registered and high for exactly one cycle on the S_RISE->S_HIGH transition.
  - oRelease is registered and high for exactly one cycle on the S_FALL->S_LOW transition.
- Any single sample of s2 matching the current stable level restarts the count. There is no partial credit.
- cnt never exceeds DEBOUNCE_LIMIT, so it never wraps.
- Reset:
  - All states go to S_LOW and cnt to 0.
  - All outputs go to 0: oSwitch, oPress, oRelease, and oLED.
  - Reset asserted mid-count abandons the count. A switch held high through reset is re-debounced from S_LOW after release and produces a fresh oPress.

## Timing

- Raw input sampled high at edge k: s2 is high after edge k+1. The FSM enters S_RISE at edge k+2 and S_HIGH at edge k+1+DEBOUNCE_LIMIT+... per the counter, i.e. oSwitch and oPress both rise DEBOUNCE_LIMIT+2 clocks after k.
- oPress and oRelease change on the same edge as oSwitch. Each is high for one cycle.
- oLED changes on the same edge as oPress (toggle mode) or oSwitch (follow mode).
- For a level held at least DEBOUNCE_LIMIT+2 clocks, input to output latency is fixed. Shorter pulses produce no output activity.

## Configuration

- LED_TOGGLE_EN defined:
  - Each oLED_n is a toggle register.
  - oLED_n inverts on every oPress_n. It is unaffected by release.
  - Reset value is 0.
- LED_TOGGLE_EN undefined:
  - oLED_n = oSwitch_n.
  - The toggle register is not synthesized.

## Structure

- Package switch_pkg:
  - NUM_SWITCHES = 4.
  - The debounce state enum (S_LOW, S_RISE, S_HIGH, S_FALL), 2 bits.
  - Default DEBOUNCE_LIMIT constant.
- Sub-module switch_debounce_channel:
  - Contains one sync stage, FSM, counter, press/release pulse flops, and the optional toggle register.
  - The top instantiates it NUM_SWITCHES times and maps the numbered ports.

## Test plan

All scenarios use DEBOUNCE_LIMIT=4 and a 10 ns clock.

- Reset check: hold iReset 3 cycles with all iSwitch=1 -> all outputs 0 during reset. After release, oSwitch_n rises exactly 6 clocks later, with one oPress_n pulse per channel.
- Clean press on iSwitch_1 at t0 -> oSwitch_1=1 and oPress_1=1 at t0+6 clocks. oPress_1 is 0 at t0+7. Other channels stay 0.
- Glitches: pulse iSwitch_2 high for 3 clocks, then low -> no oSwitch_2 or oPress_2 activity. Bounce 1,0,1 with 2-clock segments, then hold -> the count restarts on the last rise, and oPress_2 appears 6 clocks after the final rising sample.
- Release: iSwitch_3 stable high, then low -> oSwitch_3 falls and oRelease_3 pulses once, 6 clocks after the fall. No oPress_3.
- LED_TOGGLE_EN: press/release iSwitch_4 twice -> oLED_4 goes 0->1->0 on each oPress_4 edge. Without the macro, oLED_4 equals oSwitch_4 every cycle.
- Reset mid-count: assert iReset 2 clocks into S_RISE on iSwitch_1 -> no oPress_1 during or immediately after reset. A full 6-clock debounce restarts after release.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch conditioner.
//   NUM_SWITCHES           - number of independent switch channels
//   DEFAULT_DEBOUNCE_LIMIT - stable clocks required to accept a level (10 ms at 25 MHz)
//   deb_state_e            - per-channel debounce state
package switch_pkg;

    localparam int unsigned NUM_SWITCHES           = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 250000;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } deb_state_e;

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: two-flop synchronizer, debounce FSM with stability counter,
// registered press/release pulses and the LED drive.
//
// Ports:
//   clk_i      - system clock
//   rst_i      - synchronous, active-high reset
//   raw_i      - raw switch pin, asynchronous to clk_i
//   level_o    - debounced level
//   press_o    - one-cycle pulse on debounced 0->1
//   release_o  - one-cycle pulse on debounced 1->0
//   led_o      - LED drive
//
// Configuration macro LED_TOGGLE_EN: when defined, led_o is a toggle register that
// inverts on every press; otherwise led_o follows level_o and no register is built.
module switch_debounce_channel
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned CNT_W          = $clog2(DEBOUNCE_LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic led_o
);

    localparam logic [CNT_W-1:0] CntLimit = CNT_W'(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    logic       s1_q, s2_q;
    deb_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    // Next-state logic. The cycle that enters S_RISE/S_FALL already counts as the
    // first mismatching sample, so acceptance needs DEBOUNCE_LIMIT+1 in a row.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (s2_q) begin
                    state_d = S_RISE;
                    cnt_d   = CntOne;
                end
            end
            S_RISE: begin
                if (!s2_q) begin
                    state_d = S_LOW;
                end else if (cnt_q == CntLimit) begin
                    state_d = S_HIGH;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            S_HIGH: begin
                if (!s2_q) begin
                    state_d = S_FALL;
                    cnt_d   = CntOne;
                end
            end
            S_FALL: begin
                if (s2_q) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CntLimit) begin
                    state_d   = S_LOW;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = S_LOW;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= S_LOW;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = (state_q == S_HIGH) || (state_q == S_FALL);
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef LED_TOGGLE_EN
    logic led_q, led_d;

    always_comb begin
        led_d = led_q;
        if (press_d) begin
            led_d = ~led_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o = led_q;
`else
    assign led_o = level_o;
`endif

endmodule

// File: rtl/switch_conditioner.sv
// Front end for the four board switches: each raw pin is synchronized, debounced and
// edge-detected by an independent switch_debounce_channel instance.
//
// Ports:
//   iClk, iReset            - clock and synchronous active-high reset
//   iSwitch_1..4            - raw switch pins (asynchronous)
//   oSwitch_1..4            - debounced levels
//   oPress_1..4             - one-cycle pulse on debounced 0->1
//   oRelease_1..4           - one-cycle pulse on debounced 1->0
//   oLED_1..4               - LED drive
//
// Configuration macro LED_TOGGLE_EN selects toggle-on-press LEDs (defined) or LEDs
// that follow the debounced level (undefined).
module switch_conditioner
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned CNT_W          = $clog2(DEBOUNCE_LIMIT + 1)
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iSwitch_1,
    input  logic iSwitch_2,
    input  logic iSwitch_3,
    input  logic iSwitch_4,
    output logic oSwitch_1,
    output logic oSwitch_2,
    output logic oSwitch_3,
    output logic oSwitch_4,
    output logic oPress_1,
    output logic oPress_2,
    output logic oPress_3,
    output logic oPress_4,
    output logic oRelease_1,
    output logic oRelease_2,
    output logic oRelease_3,
    output logic oRelease_4,
    output logic oLED_1,
    output logic oLED_2,
    output logic oLED_3,
    output logic oLED_4
);

    logic [NUM_SWITCHES-1:0] raw;
    logic [NUM_SWITCHES-1:0] level;
    logic [NUM_SWITCHES-1:0] press;
    logic [NUM_SWITCHES-1:0] release_p;
    logic [NUM_SWITCHES-1:0] led;

    assign raw = {iSwitch_4, iSwitch_3, iSwitch_2, iSwitch_1};

    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_ch
        switch_debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk_i     (iClk),
            .rst_i     (iReset),
            .raw_i     (raw[i]),
            .level_o   (level[i]),
            .press_o   (press[i]),
            .release_o (release_p[i]),
            .led_o     (led[i])
        );
    end

    assign {oSwitch_4, oSwitch_3, oSwitch_2, oSwitch_1}     = level;
    assign {oPress_4, oPress_3, oPress_2, oPress_1}         = press;
    assign {oRelease_4, oRelease_3, oRelease_2, oRelease_1} = release_p;
    assign {oLED_4, oLED_3, oLED_2, oLED_1}                 = led;

endmodule
